mbist_march_ctrl: RTL and testbench
===================================

Name: mbist_march_ctrl

Overview:
- March C- BIST controller that sequences a single-port test memory `fault_mem`.
- Interface to the memory: write_read, address, wdata, rdata.
- Generates address/data/operation streams, compares read data against expected values and reports pass/fail with first-failure diagnostics.
- Sits between the chip-level BIST start/status interface and the memory under test; one controller per memory instance.

Parameters:
- DATA_WIDTH, 8, memory word width.
- ADDR_WIDTH, 4, memory address width.
- MEM_DEPTH, 16, number of tested words; addresses 0..MEM_DEPTH-1, MEM_DEPTH <= 2**ADDR_WIDTH.
- RD_LAT, 2, cycles from read issue (address + write_read=0) to valid rdata.
- CNT_WIDTH, 8, width of the saturating fail counter.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to run the test; sampled only in IDLE.
- busy  output  1  high from the cycle after start is accepted until done pulses.
- done  output  1  one-cycle pulse at test end.
- fail  output  1  sticky, set on any read mismatch; cleared when a new test starts.
- fail_addr  output  ADDR_WIDTH  address of the first mismatch.
- fail_elem  output  3  March element index (0..5) of the first mismatch.
- fail_count  output  CNT_WIDTH  number of mismatching read words, saturating at all-ones.
- mem_write_read  output  1  1=write, 0=read.
- mem_address  output  ADDR_WIDTH  memory address.
- mem_wdata  output  DATA_WIDTH  write data; leads its write command by one cycle.
- mem_rdata  input  DATA_WIDTH  memory read data.

Behaviour:
- Reset values: busy=0, done=0, fail=0, fail_addr=0, fail_elem=0, fail_count=0, mem_write_read=0, mem_address=0, mem_wdata=0. State = IDLE.
- Algorithm is March C-, with D0 = all zeros and D1 = all ones:
  - E0 up(w0)
  - E1 up(r0,w1)
  - E2 up(r1,w0)
  - E3 down(r0,w1)
  - E4 down(r1,w0)
  - E5 up(r0)
- "up" means address 0 to MEM_DEPTH-1; "down" means MEM_DEPTH-1 to 0.
- One memory operation is issued per cycle with no bubbles. Total operations = 10*MEM_DEPTH.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: on start=1, go to RUN next cycle. Clear fail, fail_addr, fail_elem and fail_count at the same edge.
  - RUN: issue the operation for the current (element, address, op-in-element). After the last operation of E5, go to DRAIN.
  - DRAIN: wait RD_LAT cycles so in-flight reads are compared. mem_write_read=0 and mem_address holds its last value.
  - DONE: done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- busy=1 in RUN and DRAIN. start is ignored outside IDLE.
- Write data pre-issue: the memory registers wdata one cycle before using it.
  - mem_wdata in cycle t equals the data of the write issued in cycle t+1.
  - During reads, mem_wdata already carries the next write's value.
  - In IDLE, mem_wdata=D0 so the first E0 write is correct.
- Compare pipeline: each read pushes {valid, expected, addr, elem} into an RD_LAT-deep shift register.
  - When a valid entry exits, compare it to mem_rdata.
  - On mismatch: fail_count increments (saturating).
  - If fail was 0 before the mismatch, capture fail_addr and fail_elem; fail is set at the same edge.
- Simultaneous mismatch and DRAIN->DONE: the mismatch is recorded before done asserts, because the last compare completes in the final DRAIN cycle.
- An asynchronous reset mid-run returns all state and outputs to reset values immediately. No partial results are retained.

Optional Feature:
- Macro MBIST_STOP_ON_FAIL_EN.
- When defined: on the first mismatch, the controller stops issuing operations (mem_write_read=0 from the next cycle) and goes to DRAIN. Pending reads are still compared and counted. done follows RD_LAT cycles later, giving early termination for production test.
- When undefined: the full algorithm always runs to completion regardless of failures.

Test Plan:
- Fault-free memory, MEM_DEPTH=16, RD_LAT=2; start pulsed at cycle 0 -> busy 1..162, done at cycle 163, fail=0, fail_count=0.
- Memory with transition fault on bit 1 at address 5 (1->0 blocked) -> fail=1, fail_addr=5, fail_elem=3, fail_count=2 (E3 r0 and E5 r0).
- Bit 0 stuck-at-1 at address 3 -> fail=1, fail_addr=3, fail_elem=1, fail_count=3 (E1, E3 and E5 r0).
- Check the write stream on a fault-free run -> every write to address A in cycle t has mem_wdata at t-1 equal to the element's write value. First E0 write is preceded by mem_wdata=0.
- start pulses while busy, then rst_n asserted mid-E2 -> extra starts ignored; after reset all outputs are 0. A new start runs the full sequence with correct done timing.
- With MBIST_STOP_ON_FAIL_EN and the address-3 stuck-at fault -> operation issue stops after the E1 read of address 3 is compared, done follows RD_LAT cycles later, fail_count=1.

Source files
------------

// File: rtl/mbist_march_ctrl.sv
// March C- BIST controller: sequences a single-port memory, compares reads, records first failure.
// Optional MBIST_STOP_ON_FAIL_EN: stop issuing operations at the first mismatch and drain.
module mbist_march_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned MEM_DEPTH  = 16,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [2:0]            fail_elem_o,
  output logic [CNT_WIDTH-1:0]  fail_count_o,
  output logic                  mem_write_read_o,
  output logic [ADDR_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int unsigned DrainW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_WIDTH-1:0] LastAddr  = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] AddrOne   = ADDR_WIDTH'(1);
  localparam logic [DrainW-1:0]     DrainLast = DrainW'(RD_LAT - 1);
  localparam logic [DrainW-1:0]     DrainOne  = DrainW'(1);
  localparam logic [CNT_WIDTH-1:0]  CntOne    = CNT_WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            elem;
  } rd_entry_t;

  function automatic logic is_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic is_pair(input logic [2:0] e);
    return (e >= 3'd1) && (e <= 3'd4);
  endfunction

  function automatic logic is_wr(input logic [2:0] e, input logic opi);
    return (e == 3'd0) || (is_pair(e) && opi);
  endfunction

  function automatic logic at_end(input logic [2:0] e, input logic [ADDR_WIDTH-1:0] a);
    return is_down(e) ? (a == '0) : (a == LastAddr);
  endfunction

  // Data of the first write issued strictly after the operation at (e, opi, a).
  function automatic logic [DATA_WIDTH-1:0] next_wr(input logic [2:0] e, input logic opi,
                                                    input logic [ADDR_WIDTH-1:0] a);
    logic one;
    if (e == 3'd5) begin
      one = 1'b0;
    end else if (is_wr(e, opi) && at_end(e, a)) begin
      one = (e == 3'd0) || (e == 3'd2);
    end else begin
      one = e[0];
    end
    return {DATA_WIDTH{one}};
  endfunction

  state_e                state_q;
  logic [2:0]            elem_q, nxt_elem;
  logic [ADDR_WIDTH-1:0] addr_q, nxt_addr;
  logic                  opi_q, nxt_opi, last_op;
  logic [DrainW-1:0]     drain_q;
  logic                  busy_q, done_q, mem_write_read_q;
  logic [ADDR_WIDTH-1:0] mem_address_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  logic                  fail_q, fail_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]            fail_elem_q, fail_elem_d;
  logic [CNT_WIDTH-1:0]  fail_count_q, fail_count_d;

  rd_entry_t rd_pipe_q [RD_LAT];
  rd_entry_t rd_new, rd_exit;
  logic      mismatch, stop_hit;

  // Position of the operation that follows the one currently on the memory bus.
  always_comb begin
    nxt_elem = elem_q;
    nxt_addr = addr_q;
    nxt_opi  = 1'b0;
    last_op  = 1'b0;
    if (is_pair(elem_q) && !opi_q) begin
      nxt_opi = 1'b1;
    end else if (!at_end(elem_q, addr_q)) begin
      nxt_addr = is_down(elem_q) ? addr_q - AddrOne : addr_q + AddrOne;
    end else if (elem_q == 3'd5) begin
      last_op = 1'b1;
    end else begin
      nxt_elem = elem_q + 3'd1;
      nxt_addr = is_down(elem_q + 3'd1) ? LastAddr : '0;
    end
  end

  always_comb begin
    rd_new.valid = (state_q == StRun) && !mem_write_read_q;
    rd_new.data  = {DATA_WIDTH{(elem_q == 3'd2) || (elem_q == 3'd4)}};
    rd_new.addr  = addr_q;
    rd_new.elem  = elem_q;
    rd_exit      = rd_pipe_q[RD_LAT-1];
    mismatch     = rd_exit.valid && (rd_exit.data != mem_rdata_i);
  end

`ifdef MBIST_STOP_ON_FAIL_EN
  assign stop_hit = mismatch && !fail_q;
`else
  assign stop_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      elem_q           <= '0;
      addr_q           <= '0;
      opi_q            <= 1'b0;
      drain_q          <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      mem_write_read_q <= 1'b0;
      mem_address_q    <= '0;
      mem_wdata_q      <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q          <= StRun;
            busy_q           <= 1'b1;
            elem_q           <= '0;
            addr_q           <= '0;
            opi_q            <= 1'b0;
            mem_write_read_q <= 1'b1;
            mem_address_q    <= '0;
            mem_wdata_q      <= next_wr(3'd0, 1'b0, '0);
          end
        end
        StRun: begin
          if (last_op || stop_hit) begin
            state_q          <= StDrain;
            drain_q          <= '0;
            mem_write_read_q <= 1'b0;
            mem_wdata_q      <= '0;
          end else begin
            elem_q           <= nxt_elem;
            addr_q           <= nxt_addr;
            opi_q            <= nxt_opi;
            mem_write_read_q <= is_wr(nxt_elem, nxt_opi);
            mem_address_q    <= nxt_addr;
            mem_wdata_q      <= next_wr(nxt_elem, nxt_opi, nxt_addr);
          end
        end
        StDrain: begin
          if (drain_q == DrainLast) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + DrainOne;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    fail_d       = fail_q;
    fail_addr_d  = fail_addr_q;
    fail_elem_d  = fail_elem_q;
    fail_count_d = fail_count_q;
    if ((state_q == StIdle) && start_i) begin
      fail_d       = 1'b0;
      fail_addr_d  = '0;
      fail_elem_d  = '0;
      fail_count_d = '0;
    end else if (mismatch) begin
      if (fail_count_q != '1) fail_count_d = fail_count_q + CntOne;
      if (!fail_q) begin
        fail_d      = 1'b1;
        fail_addr_d = rd_exit.addr;
        fail_elem_d = rd_exit.elem;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) rd_pipe_q[i] <= '0;
      fail_q       <= 1'b0;
      fail_addr_q  <= '0;
      fail_elem_q  <= '0;
      fail_count_q <= '0;
    end else begin
      rd_pipe_q[0] <= rd_new;
      for (int i = 1; i < RD_LAT; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
      fail_q       <= fail_d;
      fail_addr_q  <= fail_addr_d;
      fail_elem_q  <= fail_elem_d;
      fail_count_q <= fail_count_d;
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign fail_o           = fail_q;
  assign fail_addr_o      = fail_addr_q;
  assign fail_elem_o      = fail_elem_q;
  assign fail_count_o     = fail_count_q;
  assign mem_write_read_o = mem_write_read_q;
  assign mem_address_o    = mem_address_q;
  assign mem_wdata_o      = mem_wdata_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Scoreboard bench for mbist_march_ctrl with a behavioural memory and injectable faults.
`timescale 1ns/1ps
module tb_mbist_march_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int NOPS  = 10 * DEPTH;
`ifdef MBIST_STOP_ON_FAIL_EN
  localparam int AbortFault = 0;
`else
  localparam int AbortFault = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic          busy, done, fail, mem_write_read;
  logic [AW-1:0] fail_addr, mem_address;
  logic [2:0]    fail_elem;
  logic [7:0]    fail_count;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mbist_march_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_i          (start),
    .busy_o           (busy),
    .done_o           (done),
    .fail_o           (fail),
    .fail_addr_o      (fail_addr),
    .fail_elem_o      (fail_elem),
    .fail_count_o     (fail_count),
    .mem_write_read_o (mem_write_read),
    .mem_address_o    (mem_address),
    .mem_wdata_o      (mem_wdata),
    .mem_rdata_i      (mem_rdata)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: wdata registered one cycle ahead of the write; reads return after 2 cycles.
  // fault 1: bit 1 of address 5 cannot fall; fault 2: bit 0 of address 3 reads as 1.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] wd_reg = '0, rd1 = '0, rd2 = '0;
  int fault = 0;

  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = mem[a];
    if (fault == 2 && a == 4'd3) v[0] = 1'b1;
    return v;
  endfunction

  function automatic logic [DW-1:0] wr_val(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] v;
    v = d;
    if (fault == 1 && a == 4'd5 && mem[a][1] === 1'b1) v[1] = 1'b1;
    return v;
  endfunction

  always @(posedge clk) begin
    wd_reg <= mem_wdata;
    rd1    <= rd_val(mem_address);
    rd2    <= rd1;
    if (mem_write_read) mem[mem_address] <= wr_val(mem_address, wd_reg);
  end
  assign mem_rdata = rd2;

  // Expected March C- operation stream, built by hand from the algorithm.
  int exp_we [NOPS];
  int exp_ad [NOPS];
  int exp_wd [NOPS];

  task automatic build_stream();
    int n, a, wv;
    n = 0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_we[n] = 1; exp_ad[n] = i; exp_wd[n] = 8'h00; n++;
    end
    for (int e = 1; e <= 4; e++) begin
      wv = (e == 1 || e == 3) ? 8'hFF : 8'h00;
      for (int j = 0; j < DEPTH; j++) begin
        a = (e >= 3) ? DEPTH - 1 - j : j;
        exp_we[n] = 0; exp_ad[n] = a; exp_wd[n] = 0;  n++;
        exp_we[n] = 1; exp_ad[n] = a; exp_wd[n] = wv; n++;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      exp_we[n] = 0; exp_ad[n] = i; exp_wd[n] = 0; n++;
    end
  endtask

  typedef struct {
    logic fail;
    int   addr;
    int   elem;
    int   cnt;
    int   lat;
    int   busy;
  } exp_t;

  exp_t sb_q[$];

  function automatic exp_t mk(input logic f, input int a, input int e, input int c,
                              input int l, input int b);
    exp_t r;
    r.fail = f; r.addr = a; r.elem = e; r.cnt = c; r.lat = l; r.busy = b;
    return r;
  endfunction

  int   cyc = 0;
  int   start_cyc = 0;
  int   busy_base = 0;
  int   busy_total = 0;
  int   done_cnt = 0;
  int   exp_ops = NOPS;
  bit   run_active = 1'b0;
  logic [DW-1:0] prev_wd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: checks the operation stream each cycle and pops the scoreboard on done.
  always @(negedge clk) begin
    int   k;
    exp_t e;
    if (busy) busy_total++;
    if (run_active) begin
      k = cyc - start_cyc - 1;
      if (k >= 0 && k < exp_ops) begin
        check($sformatf("op%0d_we", k), mem_write_read, exp_we[k]);
        check($sformatf("op%0d_addr", k), mem_address, exp_ad[k]);
        if (exp_we[k] != 0) check($sformatf("op%0d_wdata_lead", k), prev_wd, exp_wd[k]);
      end else if (k >= exp_ops && busy) begin
        check($sformatf("drain%0d_no_issue", k), mem_write_read, 0);
      end
    end
    if (done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        check("done_expected", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        check("done_busy_low", busy, 0);
        check("done_latency", cyc - start_cyc, e.lat);
        check("busy_cycles", busy_total - busy_base, e.busy);
        check("fail", fail, e.fail);
        check("fail_addr", fail_addr, e.addr);
        check("fail_elem", fail_elem, e.elem);
        check("fail_count", fail_count, e.cnt);
      end
    end
    prev_wd = mem_wdata;
  end

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_fail"}, fail, 0);
    check({tag, "_fail_addr"}, fail_addr, 0);
    check({tag, "_fail_elem"}, fail_elem, 0);
    check({tag, "_fail_count"}, fail_count, 0);
    check({tag, "_we"}, mem_write_read, 0);
    check({tag, "_addr"}, mem_address, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
  endtask

  task automatic run_test(input int f, input exp_t e, input int nops);
    int seen;
    fault   = f;
    exp_ops = nops;
    @(negedge clk);
    seen = done_cnt;
    sb_q.push_back(e);
    start_cyc  = cyc;
    busy_base  = busy_total;
    run_active = 1'b1;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 400 && done_cnt == seen; i++) @(negedge clk);
    if (done_cnt == seen) begin
      check("done_timeout", done_cnt - seen, 1);
      sb_q.delete();
    end
    @(negedge clk);
    run_active = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    build_stream();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_test(0, mk(1'b0, 0, 0, 0, 163, 162), NOPS);
`ifdef MBIST_STOP_ON_FAIL_EN
    run_test(1, mk(1'b1, 5, 3, 1, 106, 105), 103);
    run_test(2, mk(1'b1, 3, 1, 1, 28, 27), 25);
`else
    run_test(1, mk(1'b1, 5, 3, 2, 163, 162), NOPS);
    run_test(2, mk(1'b1, 3, 1, 3, 163, 162), NOPS);
`endif

    // Aborted run: extra starts while busy, then asynchronous reset in the middle of E2.
    fault   = AbortFault;
    exp_ops = NOPS;
    @(negedge clk);
    start_cyc  = cyc;
    run_active = 1'b1;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc - start_cyc < 60) @(negedge clk);
    check("abort_busy", busy, 1);
    check("abort_fail_before_reset", fail, (AbortFault == 2) ? 1 : 0);
    #2;
    rst_n      = 1'b0;
    run_active = 1'b0;
    #1;
    check_reset("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_test(0, mk(1'b0, 0, 0, 0, 163, 162), NOPS);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
